// File: rtl/fetch_inst_queue.sv
// rtl/fetch_inst_queue.sv - instruction fetch request FSM feeding a circular queue of decoded-size instructions
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (response presented straight to decode when the queue is empty)
module fetch_inst_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    output logic        req_valid_o,
    output logic [31:0] req_addr_o,
    input  logic        res_valid_i,
    input  logic [31:0] res_inst_i,
    output logic        de_valid_o,
    input  logic        de_ready_i,
    output logic [31:0] de_pc_o,
    output logic [31:0] de_inst_o,
    output logic        de_is_comp_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [31:0]        mem_pc   [DEPTH];
    logic [31:0]        mem_inst [DEPTH];
    logic               mem_comp [DEPTH];

    logic               res_comp;
    logic [31:0]        res_inst_ext;
    logic               resp_take;
    logic               queue_empty;
    logic               bypass_hit;
    logic               push_fire;
    logic               pop_fire;

    assign res_comp     = (res_inst_i[1:0] != 2'b11);
    assign res_inst_ext = res_comp ? {16'h0000, res_inst_i[15:0]} : res_inst_i;
    assign queue_empty  = (count_q == '0);
    // A response is only meaningful while a live (non-discarded) fetch is outstanding.
    assign resp_take    = (state_q == S_WAIT) && res_valid_i && !flush_i;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_hit   = resp_take && queue_empty;
`else
    assign bypass_hit   = 1'b0;
`endif

    // Reset gating keeps the request line quiet while rst_ni is held low.
    assign req_valid_o  = rst_ni && (state_q == S_IDLE) && !flush_i && (count_q < CNT_W'(DEPTH));
    assign req_addr_o   = pc_q & ~32'h1;
    assign pop_fire     = !queue_empty && de_ready_i && !flush_i;
    // A bypassed response that decode accepts immediately never occupies a slot.
    assign push_fire    = resp_take && !(bypass_hit && de_ready_i);

    // Decode-side view: queue head first, then the bypassed response, else all zeros.
    always_comb begin
        de_valid_o   = 1'b0;
        de_pc_o      = 32'h0;
        de_inst_o    = 32'h0;
        de_is_comp_o = 1'b0;
        if (!queue_empty) begin
            de_valid_o   = 1'b1;
            de_pc_o      = mem_pc[rd_ptr_q];
            de_inst_o    = mem_inst[rd_ptr_q];
            de_is_comp_o = mem_comp[rd_ptr_q];
        end else if (bypass_hit) begin
            de_valid_o   = 1'b1;
            de_pc_o      = pc_q;
            de_inst_o    = res_inst_ext;
            de_is_comp_o = res_comp;
        end
    end

    // Fetch FSM next state: one outstanding request, responses after a flush are swallowed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_o) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (res_valid_i)  state_d = S_IDLE;
                else if (flush_i) state_d = S_DISCARD;
            end
            S_DISCARD: begin
                if (res_valid_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Fetch PC and queue bookkeeping; flush overrides any push or pop in the same cycle.
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            pc_d     = flush_pc_i & ~32'h1;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (resp_take) pc_d = pc_q + (res_comp ? 32'd2 : 32'd4);
            if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_fire, pop_fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage; contents are only observed when count says they are valid.
    always_ff @(posedge clk_i) begin
        if (push_fire && !flush_i) begin
            mem_pc[wr_ptr_q]   <= pc_q;
            mem_inst[wr_ptr_q] <= res_inst_ext;
            mem_comp[wr_ptr_q] <= res_comp;
        end
    end
endmodule

// File: tb/tb_fetch_inst_queue.sv
// tb/tb_fetch_inst_queue.sv - directed plus randomized bench for fetch_inst_queue against a queue-based reference
module tb_fetch_inst_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_pc;
    logic        req_valid_o;
    logic [31:0] req_addr_o;
    logic        res_v;
    logic [31:0] res_d;
    logic        de_valid_o;
    logic        ready;
    logic [31:0] de_pc_o;
    logic [31:0] de_inst_o;
    logic        de_is_comp_o;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        comp;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc   = RESET_PC;
    bit          m_pend = 1'b0;
    bit          m_disc = 1'b0;

    always #5 clk = ~clk;

    fetch_inst_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .flush_i      (flush),
        .flush_pc_i   (flush_pc),
        .req_valid_o  (req_valid_o),
        .req_addr_o   (req_addr_o),
        .res_valid_i  (res_v),
        .res_inst_i   (res_d),
        .de_valid_o   (de_valid_o),
        .de_ready_i   (ready),
        .de_pc_o      (de_pc_o),
        .de_inst_o    (de_inst_o),
        .de_is_comp_o (de_is_comp_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: predict outputs from the reference, compare at negedge, advance the reference at posedge.
    task automatic cycle();
        logic        e_rv;
        logic        e_dv;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_comp;
        logic        r_comp;
        logic [31:0] r_ext;
        bit          byp_show;
        bit          consumed;
        r_comp   = (res_d[1:0] != 2'b11);
        r_ext    = r_comp ? {16'h0000, res_d[15:0]} : res_d;
        e_rv     = !m_pend && !flush && (mq.size() < DEPTH);
        byp_show = BYP && (mq.size() == 0) && res_v && m_pend && !m_disc && !flush;
        e_dv = 1'b0; e_pc = 32'h0; e_inst = 32'h0; e_comp = 1'b0;
        if (mq.size() != 0) begin
            e_dv = 1'b1; e_pc = mq[0].pc; e_inst = mq[0].inst; e_comp = mq[0].comp;
        end else if (byp_show) begin
            e_dv = 1'b1; e_pc = m_pc; e_inst = r_ext; e_comp = r_comp;
        end
        @(negedge clk);
        chk("req_valid", req_valid_o, e_rv);
        chk("req_addr", req_addr_o, m_pc);
        chk("de_valid", de_valid_o, e_dv);
        chk("de_pc", de_pc_o, e_pc);
        chk("de_inst", de_inst_o, e_inst);
        chk("de_is_comp", de_is_comp_o, e_comp);
        @(posedge clk);
        if (flush) begin
            mq.delete();
            m_pc = flush_pc & ~32'h1;
            if (m_pend && !res_v) m_disc = 1'b1;
            else begin m_pend = 1'b0; m_disc = 1'b0; end
        end else begin
            consumed = 1'b0;
            if (mq.size() != 0 && ready) void'(mq.pop_front());
            else if (byp_show && ready) consumed = 1'b1;
            if (m_pend && res_v) begin
                if (!m_disc) begin
                    if (!consumed) mq.push_back('{pc: m_pc, inst: r_ext, comp: r_comp});
                    m_pc = m_pc + (r_comp ? 32'd2 : 32'd4);
                end
                m_pend = 1'b0;
                m_disc = 1'b0;
            end else if (e_rv) begin
                m_pend = 1'b1;
            end
        end
        #1;
    endtask

    // Wait (bounded) for a live outstanding request, then return one response.
    task automatic fetch(input logic [31:0] d);
        int n = 0;
        res_v = 1'b0;
        while (!(m_pend && !m_disc) && n < 20) begin
            cycle();
            n++;
        end
        vectors++;
        assert (m_pend && !m_disc) else begin
            miscompares++;
            $error("FAIL fetch_timeout observed=%0d expected=1", m_pend);
        end
        res_v = 1'b1;
        res_d = d;
        cycle();
        res_v = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; flush_pc = 32'h0; res_v = 1'b0; res_d = 32'h0; ready = 1'b0;
        #12;
        chk("rst_req_valid", req_valid_o, 1'b0);
        chk("rst_req_addr", req_addr_o, RESET_PC);
        chk("rst_de_valid", de_valid_o, 1'b0);
        chk("rst_de_pc", de_pc_o, 32'h0);
        chk("rst_de_inst", de_inst_o, 32'h0);
        chk("rst_de_comp", de_is_comp_o, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_req_valid", req_valid_o, 1'b1);
        chk("post_rst_req_addr", req_addr_o, 32'h8000_0000);
        chk("post_rst_de_valid", de_valid_o, 1'b0);

        // Mixed 16/32-bit responses.
        fetch(32'h0000_4501);
        fetch(32'h0051_0513);
        chk("mix_pc0", de_pc_o, 32'h8000_0000);
        chk("mix_comp0", de_is_comp_o, 1'b1);
        chk("mix_inst0", de_inst_o, 32'h0000_4501);
        chk("mix_next_addr", req_addr_o, 32'h8000_0006);
        ready = 1'b1;
        cycle();
        chk("mix_pc1", de_pc_o, 32'h8000_0002);
        chk("mix_comp1", de_is_comp_o, 1'b0);
        chk("mix_inst1", de_inst_o, 32'h0051_0513);
        ready = 1'b0;

        // Flush coinciding with the response returns straight to IDLE, then fill the queue.
        flush = 1'b1; flush_pc = 32'h8000_0000; res_v = 1'b1; res_d = 32'h0000_0013;
        cycle();
        flush = 1'b0; res_v = 1'b0;
        for (int i = 0; i < DEPTH; i++) fetch($urandom);
        chk("full_req_valid", req_valid_o, 1'b0);
        ready = 1'b1;
        cycle();
        ready = 1'b0;
        chk("after_pop_req_valid", req_valid_o, 1'b1);

        // Flush while a fetch is outstanding: late response must be dropped.
        cycle();
        flush = 1'b1; flush_pc = 32'h8000_0101;
        cycle();
        flush = 1'b0;
        cycle();
        cycle();
        chk("discard_de_valid", de_valid_o, 1'b0);
        chk("discard_req_valid", req_valid_o, 1'b0);
        res_v = 1'b1; res_d = $urandom;
        cycle();
        res_v = 1'b0;
        chk("flush_de_valid", de_valid_o, 1'b0);
        chk("flush_req_valid", req_valid_o, 1'b1);
        chk("flush_req_addr", req_addr_o, 32'h8000_0100);

        // 32-bit instruction at the top of the address space wraps to zero.
        flush = 1'b1; flush_pc = 32'hFFFF_FFFC;
        cycle();
        flush = 1'b0;
        fetch(32'h0000_0013);
        chk("wrap_req_addr", req_addr_o, 32'h0000_0000);
        chk("wrap_de_pc", de_pc_o, 32'hFFFF_FFFC);
        ready = 1'b1;
        cycle();

        // Empty queue, decode ready: response latency to de_valid_o.
        res_v = 1'b1; res_d = 32'h0000_0001;
        #1;
        chk("bypass_same_cycle", de_valid_o, BYP);
        cycle();
        res_v = 1'b0;
        #1;
        chk("bypass_next_cycle", de_valid_o, !BYP);
        cycle();
        ready = 1'b0;

        // Randomized traffic, including spurious responses while idle.
        for (int i = 0; i < 600; i++) begin
            flush    = ($urandom_range(0, 19) == 0);
            flush_pc = $urandom;
            ready    = $urandom_range(0, 1);
            res_v    = m_pend ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
            res_d    = $urandom;
            if ($urandom_range(0, 1) == 1) res_d[1:0] = 2'b11;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fetch_inst_queue.md
FETCH_INST_QUEUE -- requirements
Module: fetch_inst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4 (power of two, >=2): queue entries.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000: first fetch address.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  discard queue and in-flight fetch, redirect PC.
REQ-006 SHALL have port flush_pc_i  input  32  redirect target, sampled when flush_i=1.
REQ-007 SHALL have port req_valid_o  output  1  fetch request to the align buffer.
REQ-008 SHALL have port req_addr_o  output  32  halfword-aligned fetch address.
REQ-009 SHALL have port res_valid_i  input  1  align buffer returns a 32-bit parcel pair.
REQ-010 SHALL have port res_inst_i  input  32  returned bits; [15:0] at req_addr_o.
REQ-011 SHALL have port de_valid_o  output  1  head entry valid to decode.
REQ-012 SHALL have port de_ready_i  input  1  decode accepts head entry.
REQ-013 SHALL have port de_pc_o  output  32  PC of head entry.
REQ-014 SHALL have port de_inst_o  output  32  instruction; compressed entries zero-extended from 16 bits.
REQ-015 SHALL have port de_is_comp_o  output  1  head entry is a 16-bit instruction.

Function
REQ-016 SHALL run FSM IDLE -> WAIT when req_valid_o=1; WAIT -> IDLE on res_valid_i; WAIT -> DISCARD on flush_i; DISCARD -> IDLE on res_valid_i (response dropped).
REQ-017 SHALL assert req_valid_o only in IDLE, flush_i=0, and count < DEPTH; at most one request outstanding.
REQ-018 SHALL hold req_addr_o = fetch PC register with bit 0 forced 0, stable while in WAIT.
REQ-019 SHALL, on res_valid_i in WAIT without flush_i, push {pc, inst, is_comp}; is_comp = (res_inst_i[1:0] != 2'b11).
REQ-020 SHALL advance fetch PC by 2 when is_comp, else by 4; 32-bit modulo wrap (32'hFFFF_FFFE + 2 -> 0).
REQ-021 SHALL pop the head when de_valid_o && de_ready_i; de_valid_o = (count != 0).
REQ-022 SHALL allow push and pop in the same cycle, count unchanged, including when full.
REQ-023 SHALL use DEPTH-entry circular buffer, read/write pointers wrapping DEPTH-1 -> 0, count width clog2(DEPTH)+1.
REQ-024 SHALL, on flush_i, clear count/pointers, load fetch PC with flush_pc_i & ~1, suppress any same-cycle push and pop, and go to DISCARD if in WAIT without same-cycle res_valid_i, else IDLE.
REQ-025 SHALL allow first request at redirected PC in cycle after flush_i (IDLE path).
REQ-026 SHALL ignore res_valid_i in IDLE (no push, no PC change).

Reset
REQ-027 SHALL on rst_ni=0 asynchronously set FSM=IDLE, fetch PC=RESET_PC, count=0, pointers=0.
REQ-028 SHALL drive during reset: req_valid_o=0, req_addr_o=RESET_PC, de_valid_o=0, de_pc_o=0, de_inst_o=0, de_is_comp_o=0.
REQ-029 SHALL drop an in-flight response returning after reset release unless in WAIT (reset mid-fetch -> IDLE, response ignored).

Configuration
REQ-030 SHALL, with FETCH_QUEUE_BYPASS_EN defined, present a response directly on de_* in the same cycle when count=0 and no flush; if de_ready_i=1 it is not written, else it is pushed.
REQ-031 SHALL, without FETCH_QUEUE_BYPASS_EN, present responses only from the queue: minimum 1 cycle res_valid_i -> de_valid_o.

Verification
REQ-032 SHALL cover reset: after rst_ni release -> req_valid_o=1, req_addr_o=32'h8000_0000, de_valid_o=0.
REQ-033 SHALL cover mixed sizes: responses 32'h0000_4501 then 32'h0051_0513 -> de_pc 8000_0000 (is_comp=1, inst=32'h4501), 8000_0002 (is_comp=0); next req_addr 8000_0006.
REQ-034 SHALL cover full: de_ready_i=0, DEPTH=4 pushes -> req_valid_o=0; one pop -> req_valid_o=1 next cycle.
REQ-035 SHALL cover flush in WAIT: flush_pc_i=32'h8000_0101 -> queue empty, late res_valid_i dropped, next req_addr=32'h8000_0100.
REQ-036 SHALL cover wrap: PC 32'hFFFF_FFFC with 32-bit instruction -> next req_addr=0.
REQ-037 SHALL cover bypass: empty, de_ready_i=1, res_valid_i -> de_valid_o same cycle with FETCH_QUEUE_BYPASS_EN, one cycle later without.
